// File: rtl/stream_demux_pkg.sv
// ============================================================================
//  Module   : stream_demux_pkg
//  Purpose  : Shared types and constants for the 1-to-N stream demultiplexer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_demux_pkg;

    localparam int DROP_CNT_W = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ============================================================================
//  Module   : demux_slot
//  Purpose  : One-entry output holding slot with an EMPTY/FULL handshake FSM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              free
);

    slot_state_e       state_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (load) begin
                        state_q <= SLOT_FULL;
                        data_q  <= load_data;
                    end
                end
                SLOT_FULL: begin
                    // A load while draining replaces the beat without a bubble.
                    if (load) begin
                        data_q <= load_data;
                    end else if (out_ready) begin
                        state_q <= SLOT_EMPTY;
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
        end
    end

    assign out_valid = (state_q == SLOT_FULL);
    assign out_data  = data_q;
    assign free      = !out_valid || out_ready;

endmodule

`default_nettype wire

// File: rtl/stream_demux_1xn.sv
// ============================================================================
//  Module   : stream_demux_1xn
//  Purpose  : Registered 1-to-N stream demux with broadcast and drop counting.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W = 1,
    parameter  int N_CH   = 8,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_bcast,
    output logic [N_CH-1:0]        out_valid,
    input  logic [N_CH-1:0]        out_ready,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [DROP_CNT_W-1:0]  drop_count
);

    logic [N_CH-1:0]       w_sel_onehot;
    logic [N_CH-1:0]       w_free;
    logic [N_CH-1:0]       w_load;
    logic                  w_sel_legal;
    logic                  w_handshake;
    logic                  w_drop;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d;

    // An out-of-range select decodes to all zeros, which also marks it illegal.
    always_comb begin
        w_sel_onehot = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_onehot[k] = 1'b1;
            end
        end
    end

    assign w_sel_legal = |w_sel_onehot;

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (in_bcast) begin
                in_ready = &w_free;
            end else if (w_sel_legal) begin
                in_ready = |(w_sel_onehot & w_free);
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign w_handshake = in_valid && in_ready;
    assign w_load      = w_handshake ? (in_bcast ? {N_CH{1'b1}} : w_sel_onehot) : '0;
    assign w_drop      = w_handshake && !in_bcast && !w_sel_legal;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (w_drop && (drop_cnt_q != DROP_CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (w_load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W]),
            .free      (w_free[k])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_demux_1xn.sv
// ============================================================================
//  Module   : tb_stream_demux_1xn
//  Purpose  : Directed self-checking bench for the 1-to-N stream demux.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_demux_1xn;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Eight-channel instance
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [7:0]  a_in_data  = '0;
    logic [2:0]  a_in_sel   = '0;
    logic        a_in_bcast = 1'b0;
    logic [7:0]  a_out_valid;
    logic [7:0]  a_out_ready = '0;
    logic [63:0] a_out_data;
    logic [15:0] a_drop;

    // Six-channel instance: selects 6 and 7 are illegal
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in_data  = '0;
    logic [2:0]  b_in_sel   = '0;
    logic        b_in_bcast = 1'b0;
    logic [5:0]  b_out_valid;
    logic [5:0]  b_out_ready = '0;
    logic [47:0] b_out_data;
    logic [15:0] b_drop;

    stream_demux_1xn #(.DATA_W(8), .N_CH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_sel(a_in_sel), .in_bcast(a_in_bcast),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .drop_count(a_drop)
    );

    stream_demux_1xn #(.DATA_W(8), .N_CH(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_sel(b_in_sel), .in_bcast(b_in_bcast),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .drop_count(b_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  exp_d [8];
    logic [7:0]  exp_v;
    logic [63:0] exp_bus;

    initial begin
        // ---------------- reset ----------------
        a_in_valid = 1'b1;
        a_in_sel   = 3'd1;
        tick();
        chk_eq("in_ready_in_reset", {63'd0, a_in_ready}, 64'd0);
        tick();
        chk_eq("reset_out_valid", {56'd0, a_out_valid}, 64'd0);
        chk_eq("reset_out_data", a_out_data, 64'd0);
        chk_eq("reset_drop", {48'd0, a_drop}, 64'd0);
        a_in_valid = 1'b0;
        rst_n      = 1'b1;
        tick();

        // ---------------- unicast to channel 5 ----------------
        a_out_ready = 8'hFF;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h01;
        a_in_sel    = 3'd5;
        #1;
        chk_eq("uni_in_ready", {63'd0, a_in_ready}, 64'd1);
        tick();
        a_in_valid = 1'b0;
        chk_eq("uni_out_valid", {56'd0, a_out_valid}, 64'h20);
        chk_eq("uni_out_data", a_out_data, 64'h0000_0100_0000_0000);
        tick();
        chk_eq("uni_drained", {56'd0, a_out_valid}, 64'h00);

        // ---------------- stall channel 3 ----------------
        a_out_ready = 8'hF7;
        a_in_valid  = 1'b1;
        a_in_data   = 8'hA3;
        a_in_sel    = 3'd3;
        #1;
        chk_eq("stall_first_ready", {63'd0, a_in_ready}, 64'd1);
        tick();
        a_in_data = 8'hB3;
        #1;
        chk_eq("stall_second_blocked", {63'd0, a_in_ready}, 64'd0);
        repeat (2) begin
            tick();
            chk_eq("stall_valid_held", {56'd0, a_out_valid}, 64'h08);
            chk_eq("stall_data_held", {56'd0, a_out_data[3*8 +: 8]}, 64'hA3);
            chk_eq("stall_still_blocked", {63'd0, a_in_ready}, 64'd0);
        end
        a_out_ready = 8'hFF;
        #1;
        chk_eq("stall_released_ready", {63'd0, a_in_ready}, 64'd1);
        tick();
        a_in_valid = 1'b0;
        chk_eq("stall_second_valid", {56'd0, a_out_valid}, 64'h08);
        chk_eq("stall_second_data", {56'd0, a_out_data[3*8 +: 8]}, 64'hB3);
        tick();
        chk_eq("stall_drained", {56'd0, a_out_valid}, 64'h00);

        // ---------------- broadcast blocked by channel 2 ----------------
        a_out_ready = 8'hFB;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h22;
        a_in_sel    = 3'd2;
        tick();
        a_in_data  = 8'hCC;
        a_in_bcast = 1'b1;
        a_in_sel   = 3'd7;
        #1;
        chk_eq("bcast_blocked_ready", {63'd0, a_in_ready}, 64'd0);
        tick();
        chk_eq("bcast_no_partial", {56'd0, a_out_valid}, 64'h04);
        chk_eq("bcast_ch2_kept", {56'd0, a_out_data[2*8 +: 8]}, 64'h22);
        a_out_ready = 8'hFF;
        #1;
        chk_eq("bcast_ready", {63'd0, a_in_ready}, 64'd1);
        tick();
        a_in_valid  = 1'b0;
        a_in_bcast  = 1'b0;
        a_out_ready = 8'h00;
        chk_eq("bcast_all_valid", {56'd0, a_out_valid}, 64'hFF);
        chk_eq("bcast_all_data", a_out_data, {8{8'hCC}});
        chk_eq("bcast_no_drop", {48'd0, a_drop}, 64'd0);
        tick();
        chk_eq("bcast_held", {56'd0, a_out_valid}, 64'hFF);
        a_out_ready = 8'hFF;
        tick();
        chk_eq("bcast_drained", {56'd0, a_out_valid}, 64'h00);

        // ---------------- random streaming, all consumers ready ----------------
        for (int k = 0; k < 8; k++) exp_d[k] = 8'hCC;
        for (int c = 0; c < 1000; c++) begin
            a_in_valid = 1'($urandom_range(0, 3) != 0);
            a_in_bcast = 1'($urandom_range(0, 15) == 0);
            a_in_sel   = 3'($urandom_range(0, 7));
            a_in_data  = 8'($urandom);
            exp_v = 8'h00;
            if (a_in_valid) exp_v = a_in_bcast ? 8'hFF : (8'h01 << a_in_sel);
            for (int k = 0; k < 8; k++) if (exp_v[k]) exp_d[k] = a_in_data;
            for (int k = 0; k < 8; k++) exp_bus[k*8 +: 8] = exp_d[k];
            #1;
            chk_eq("rnd_in_ready", {63'd0, a_in_ready}, 64'd1);
            tick();
            chk_eq("rnd_out_valid", {56'd0, a_out_valid}, {56'd0, exp_v});
            chk_eq("rnd_out_data", a_out_data, exp_bus);
        end
        a_in_valid = 1'b0;
        a_in_bcast = 1'b0;
        tick();

        // ---------------- reset with four slots full ----------------
        a_out_ready = 8'h00;
        a_in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_in_sel  = 3'(k);
            a_in_data = 8'h50 + 8'(k);
            tick();
        end
        a_in_valid = 1'b0;
        chk_eq("pre_reset_full", {56'd0, a_out_valid}, 64'h0F);
        rst_n      = 1'b0;
        a_in_valid = 1'b1;
        a_in_sel   = 3'd4;
        #1;
        chk_eq("midreset_in_ready", {63'd0, a_in_ready}, 64'd0);
        tick();
        chk_eq("midreset_out_valid", {56'd0, a_out_valid}, 64'h00);
        chk_eq("midreset_out_data", a_out_data, 64'd0);
        chk_eq("midreset_drop", {48'd0, a_drop}, 64'd0);
        a_in_valid = 1'b0;
        rst_n      = 1'b1;
        tick();

        // ---------------- six channels: illegal selects ----------------
        b_out_ready = 6'h3F;
        b_in_valid  = 1'b1;
        b_in_data   = 8'h77;
        b_in_sel    = 3'd7;
        #1;
        chk_eq("drop_in_ready", {63'd0, b_in_ready}, 64'd1);
        repeat (3) tick();
        b_in_valid = 1'b0;
        chk_eq("drop_count3", {48'd0, b_drop}, 64'd3);
        chk_eq("drop_no_valid", {58'd0, b_out_valid}, 64'h00);
        b_in_valid = 1'b1;
        b_in_sel   = 3'd6;
        tick();
        b_out_ready = 6'h00;
        b_in_sel    = 3'd5;
        b_in_data   = 8'h55;
        tick();
        b_in_valid = 1'b0;
        chk_eq("legal_after_drop_valid", {58'd0, b_out_valid}, 64'h20);
        chk_eq("legal_after_drop_data", {56'd0, b_out_data[5*8 +: 8]}, 64'h55);
        chk_eq("drop_count4", {48'd0, b_drop}, 64'd4);
        b_in_valid = 1'b1;
        b_in_sel   = 3'd7;
        #1;
        chk_eq("drop_ready_ch5_stalled", {63'd0, b_in_ready}, 64'd1);
        repeat (65530) tick();
        chk_eq("drop_count_fffe", {48'd0, b_drop}, 64'hFFFE);
        tick();
        chk_eq("drop_count_ffff", {48'd0, b_drop}, 64'hFFFF);
        repeat (3) tick();
        b_in_valid = 1'b0;
        chk_eq("drop_count_saturated", {48'd0, b_drop}, 64'hFFFF);
        chk_eq("drop_slot_untouched", {58'd0, b_out_valid}, 64'h20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_demux_1xn.md
# stream_demux_1xn

Parametrised, registered 1-to-N stream demultiplexer with per-channel valid/ready handshake, a one-entry holding slot per output, and a broadcast mode. It replaces the combinational 1x8 demux in datapaths where the consumers can stall. It sits between a single producer stream and N independent consumers. Illegal channel selects are dropped and counted rather than silently aliased.

## Interface
- `DATA_W`, default 1: payload width in bits.
- `N_CH`, default 8: number of output channels, 2..64; non-power-of-two allowed.
- `SEL_W` (localparam): `$clog2(N_CH)`, the select width.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  producer has a beat.
- `in_ready`  out  1  beat accepted this cycle when `in_valid && in_ready`.
- `in_data`  in  DATA_W  payload.
- `in_sel`  in  SEL_W  target channel; ignored when `in_bcast=1`.
- `in_bcast`  in  1  deliver the beat to all N_CH channels.
- `out_valid`  out  N_CH  channel k slot holds a beat.
- `out_ready`  in  N_CH  consumer k takes the beat this cycle.
- `out_data`  out  N_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W].
- `drop_count`  out  16  saturating count of dropped beats with an illegal select.

## Operation
- Each channel has one slot, a 2-state FSM:
  - EMPTY→FULL on load.
  - FULL→EMPTY when `out_ready[k]` is high and there is no load.
  - FULL→FULL (data replaced) when `out_ready[k]` is high and there is a load in the same cycle.
- `free[k] = !out_valid[k] || out_ready[k]`.
- Unicast (`in_bcast=0`) with `in_sel < N_CH`:
  - `in_ready = free[in_sel]`.
  - On handshake, only slot `in_sel` loads `in_data`.
- Unicast with `in_sel >= N_CH`:
  - `in_ready = 1`.
  - Beat discarded; `drop_count` increments, saturating at 16'hFFFF.
  - No slot changes.
- Broadcast (`in_bcast=1`):
  - `in_ready = &free`.
  - On handshake, every slot loads `in_data`; this is all-or-nothing.
  - No partial delivery.
  - `in_sel` is ignored and never counts as a drop.
- `in_ready` is combinational from `out_valid`, `out_ready`, `in_sel` and `in_bcast`. It does not depend on `in_valid`.
- `out_data[k]` is stable while `out_valid[k]=1` and `out_ready[k]=0`.
- Producer rule: once asserted, `in_valid`, `in_data`, `in_sel` and `in_bcast` are held until the handshake. Violations are undefined.

## Timing
- Latency: a beat accepted at edge t appears on `out_valid`/`out_data` after edge t, i.e. one cycle.
- Throughput: one beat per cycle to any channel whose `out_ready` is held high. Back-to-back beats to the same channel run without bubbles.
- Channels are independent: a stalled channel blocks only unicast to itself and all broadcasts.
- Reset (`rst_n=0` at an edge):
  - All `out_valid` = 0, all `out_data` = 0, `drop_count` = 0.
  - `in_ready` is forced to 0 while `rst_n=0`.
  - Reset mid-stream discards held beats with no partial output.
- First accept is possible in the first cycle after `rst_n` is sampled high.
- Saturation: `drop_count` stays at 16'hFFFF on further drops.

## Structure
- Package `stream_demux_pkg`:
  - `DROP_CNT_W` = 16.
  - `DROP_CNT_MAX`.
  - `slot_state_e` {SLOT_EMPTY, SLOT_FULL}.
- Sub-module `demux_slot`:
  - One instance per channel in a generate loop.
  - Holds the valid/data register and the EMPTY/FULL FSM.
  - Ports: `clk`, `rst_n`, `load`, `load_data`, `out_ready`, `out_valid`, `out_data`, `free`.
- Top level holds the select decode, `in_ready` logic and the drop counter.

## Test plan
- Reset, then unicast `in_data=1`, `in_sel=5`, `out_ready=8'hFF` → `out_valid=8'h20` one cycle later, `out_data[5]=1`, other channels 0.
- `out_ready[3]=0`, two beats to channel 3 → first loads; `in_ready=0` on the second until `out_ready[3]` rises; first beat held stable; second appears the cycle after release.
- Broadcast beat with `out_valid[2]=1` and `out_ready[2]=0` → `in_ready=0` and no slot loads; raise `out_ready[2]` → all 8 slots load in the same cycle.
- `N_CH=6`, unicast `in_sel=7` three times → `in_ready=1`, no `out_valid` change, `drop_count=3`; force the count near saturation → it stays at 16'hFFFF.
- Continuous random traffic with all `out_ready=1` for 1000 cycles → scoreboard shows every beat delivered in order per channel with 1-cycle latency and no bubbles.
- Assert `rst_n=0` with 4 slots full → next cycle `out_valid=0`, `out_data=0`, `drop_count=0`, and `in_ready=0` during reset.
